// File: rtl/pixel_reader_if.sv
// pixel_reader_if: bundles the three buses of the pixel reader -- the Avalon-MM
// control slave (avs_*), the Avalon-MM read master (avm_*) and the Avalon-ST
// pixel source (aso_*). The "master" modport is the pixel reader's view; the
// "slave" modport is the surrounding system (CPU, memory fabric, sink).
interface pixel_reader_if;
    // control-register slave
    logic        avs_slave_chipselect;
    logic        avs_slave_read;
    logic        avs_slave_write;
    logic [1:0]  avs_slave_address;
    logic [31:0] avs_slave_writedata;
    logic [31:0] avs_slave_readdata;
    // memory read master
    logic        avm_master_waitrequest;
    logic        avm_master_readdatavalid;
    logic [15:0] avm_master_readdata;
    logic [31:0] avm_master_address;
    logic        avm_master_read;
    logic [1:0]  avm_master_byteenable;
    // pixel stream source
    logic        aso_out_ready;
    logic        aso_out_valid;
    logic        aso_out_startofpacket;
    logic        aso_out_endofpacket;
    logic [15:0] aso_out_data;

    modport master (
        input  avs_slave_chipselect, avs_slave_read, avs_slave_write,
        input  avs_slave_address, avs_slave_writedata,
        output avs_slave_readdata,
        input  avm_master_waitrequest, avm_master_readdatavalid, avm_master_readdata,
        output avm_master_address, avm_master_read, avm_master_byteenable,
        input  aso_out_ready,
        output aso_out_valid, aso_out_startofpacket, aso_out_endofpacket, aso_out_data
    );

    modport slave (
        output avs_slave_chipselect, avs_slave_read, avs_slave_write,
        output avs_slave_address, avs_slave_writedata,
        input  avs_slave_readdata,
        output avm_master_waitrequest, avm_master_readdatavalid, avm_master_readdata,
        input  avm_master_address, avm_master_read, avm_master_byteenable,
        output aso_out_ready,
        input  aso_out_valid, aso_out_startofpacket, aso_out_endofpacket, aso_out_data
    );
endinterface

// File: rtl/pixel_reader.sv
// pixel_reader: fetches a WIDTH x HEIGHT frame of 16-bit pixels from memory
// (fixed 1 KiB line pitch, 2-byte pixel pitch) and emits it as an Avalon-ST
// packet. Reads are only issued while outstanding reads plus FIFO occupancy
// leave room in the output FIFO, so returning data can never overflow it.
// Optional feature: define PIXEL_READER_FRAMECOUNT_EN to get a 32-bit
// completed-frame counter in register 3 (FRAMES); otherwise FRAMES reads 0.
module pixel_reader #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           csi_clockreset_clk,
    input  logic           csi_clockreset_resetn,
    pixel_reader_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [8:0]    X_LAST  = 9'(WIDTH - 1);
    localparam logic [7:0]    Y_LAST  = 8'(HEIGHT - 1);
    localparam logic [CW:0]   CREDIT  = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic          aborting_q;
    logic [31:0]   base_q;
    logic [31:0]   frame_base_q;
    logic [8:0]    x_q;
    logic [7:0]    y_q;
    logic          rd_q;
    logic          busy_q, done_q, aborted_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [8:0]    ox_q;
    logic [7:0]    oy_q;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [31:0]   frames_w;

    logic          ctrl_wr, base_wr, go, abort_wr, flush;
    logic          accept, rsp, push, pop, last_px;
    logic          fetch_more, credit_ok, rd_nx, abort_done, drain_done;
    logic [CW-1:0] outst_nx, cnt_nx;

    // Decode strobes and work out next-cycle credit and read request.
    always_comb begin
        ctrl_wr  = bus.avs_slave_chipselect && bus.avs_slave_write && (bus.avs_slave_address == 2'd1);
        base_wr  = bus.avs_slave_chipselect && bus.avs_slave_write && (bus.avs_slave_address == 2'd0);
        go       = ctrl_wr && bus.avs_slave_writedata[0] && (state_q == IDLE);
        abort_wr = ctrl_wr && bus.avs_slave_writedata[1] && (state_q != IDLE);
        flush    = abort_wr || aborting_q;
        accept   = rd_q && !bus.avm_master_waitrequest;
        // A return with nothing outstanding is a fabric protocol error; drop it.
        rsp      = bus.avm_master_readdatavalid && (outst_q != '0);
        push     = rsp && !flush;
        pop      = (cnt_q != '0) && bus.aso_out_ready;
        last_px  = (x_q == X_LAST) && (y_q == Y_LAST);

        outst_nx = outst_q;
        if (accept) outst_nx = outst_nx + CNT_ONE;
        if (rsp)    outst_nx = outst_nx - CNT_ONE;

        cnt_nx = cnt_q;
        if (flush) begin
            cnt_nx = '0;
        end else begin
            if (push) cnt_nx = cnt_nx + CNT_ONE;
            if (pop)  cnt_nx = cnt_nx - CNT_ONE;
        end

        // Strictly less: an asserted read is itself a claim on one FIFO slot.
        credit_ok  = ({1'b0, outst_nx} + {1'b0, cnt_nx}) < CREDIT;
        fetch_more = (state_q == FETCH) && !flush && !(accept && last_px);

        if (go)              rd_nx = 1'b1;
        else if (fetch_more) rd_nx = credit_ok;
        else                 rd_nx = rd_q && bus.avm_master_waitrequest; // finish a stalled read

        abort_done = flush && (state_q != IDLE) && (outst_nx == '0) && !rd_nx;
        drain_done = (state_q == DRAIN) && !flush && (outst_nx == '0) && (cnt_nx == '0);
    end

    // Control FSM: frame walk, abort handling, status bits and read strobe.
    always_ff @(posedge csi_clockreset_clk) begin
        if (!csi_clockreset_resetn) begin
            state_q      <= IDLE;
            aborting_q   <= 1'b0;
            base_q       <= '0;
            frame_base_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            outst_q      <= '0;
        end else begin
            outst_q <= outst_nx;
            rd_q    <= rd_nx;
            if (base_wr) base_q <= {bus.avs_slave_writedata[31:2], 2'b00};
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q      <= FETCH;
                        frame_base_q <= base_q;
                        x_q          <= '0;
                        y_q          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        aborted_q    <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + 8'd1;
                        end else begin
                            x_q <= x_q + 9'd1;
                        end
                    end
                    if (abort_wr) aborting_q <= 1'b1;
                    if (abort_done) begin
                        state_q    <= IDLE;
                        aborting_q <= 1'b0;
                        busy_q     <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (drain_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if ((state_q == FETCH) && accept && last_px && !flush) begin
                        state_q <= DRAIN;
                    end
                end
            endcase
        end
    end

    // Output FIFO bookkeeping plus the output pixel position used for sop/eop.
    always_ff @(posedge csi_clockreset_clk) begin
        if (!csi_clockreset_resetn) begin
            cnt_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            cnt_q <= cnt_nx;
            if (flush) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (push) wp_q <= wp_q + PTR_ONE;
                if (pop)  rp_q <= rp_q + PTR_ONE;
            end
            if (go) begin
                ox_q <= '0;
                oy_q <= '0;
            end else if (pop && !flush) begin
                if (ox_q == X_LAST) begin
                    ox_q <= '0;
                    oy_q <= oy_q + 8'd1;
                end else begin
                    ox_q <= ox_q + 9'd1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge csi_clockreset_clk) begin
        if (push) mem[wp_q] <= bus.avm_master_readdata;
    end

`ifdef PIXEL_READER_FRAMECOUNT_EN
    logic [31:0] frames_q;

    // Count frames that drain to completion; aborted frames never get here.
    always_ff @(posedge csi_clockreset_clk) begin
        if (!csi_clockreset_resetn) frames_q <= '0;
        else if (drain_done)        frames_q <= frames_q + 32'd1;
    end

    assign frames_w = frames_q;
`else
    assign frames_w = '0;
`endif

    // Register read mux, zero wait states.
    always_comb begin
        bus.avs_slave_readdata = '0;
        if (bus.avs_slave_chipselect && bus.avs_slave_read) begin
            case (bus.avs_slave_address)
                2'd0:    bus.avs_slave_readdata = base_q;
                2'd2:    bus.avs_slave_readdata = {29'd0, aborted_q, done_q, busy_q};
                2'd3:    bus.avs_slave_readdata = frames_w;
                default: bus.avs_slave_readdata = '0;
            endcase
        end
    end

    assign bus.avm_master_read       = rd_q;
    assign bus.avm_master_byteenable = 2'b11;
    assign bus.avm_master_address    = frame_base_q + {14'd0, y_q, 10'd0} + {22'd0, x_q, 1'b0};

    assign bus.aso_out_valid         = (cnt_q != '0);
    assign bus.aso_out_data          = mem[rp_q];
    assign bus.aso_out_startofpacket = bus.aso_out_valid && (ox_q == '0) && (oy_q == '0);
    assign bus.aso_out_endofpacket   = bus.aso_out_valid && (ox_q == X_LAST) && (oy_q == Y_LAST);
endmodule

// File: doc/pixel_reader.md
PIXEL_READER -- requirements
Module: pixel_reader

Interface
REQ-001 Parameter WIDTH, 320, pixels per line (1..512).
REQ-002 Parameter HEIGHT, 240, lines per frame (1..256).
REQ-003 Parameter FIFO_DEPTH, 8, output FIFO entries (power of 2, 4..64).
REQ-004 csi_clockreset_clk  in  1  sole clock, all logic rising-edge.
REQ-005 csi_clockreset_resetn  in  1  reset, synchronous, active-low.
REQ-006 avs_slave_chipselect, avs_slave_read, avs_slave_write  in  1 each  control-register access strobes.
REQ-007 avs_slave_address  in  2  register index; avs_slave_writedata in 32; avs_slave_readdata out 32.
REQ-008 avm_master_waitrequest  in  1  fabric stall; avm_master_readdatavalid in 1; avm_master_readdata in 16.
REQ-009 avm_master_address  out  32  byte address; avm_master_read out 1; avm_master_byteenable out 2, constant 2'b11.
REQ-010 aso_out_ready  in  1; aso_out_valid, aso_out_startofpacket, aso_out_endofpacket  out  1 each; aso_out_data  out  16  pixel stream.

Function
REQ-011 Registers: 0 BASE (RW, bits[1:0] forced 0); 1 CONTROL (W: bit0 Go, bit1 Abort; reads 0); 2 STATUS (R: bit0 Busy, bit1 Done, bit2 Aborted); 3 FRAMES (R, see Configuration).
REQ-012 Register reads combinational from address; zero wait states; writes take effect next edge.
REQ-013 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on Go write; Go while not IDLE ignored.
REQ-014 On Go: latch BASE, x=0, y=0, clear Done and Aborted, set Busy.
REQ-015 Address = BASE + (y<<10) + (x<<1); x 9-bit, y 8-bit.
REQ-016 FETCH asserts avm_master_read when credit available; address/read held stable while waitrequest=1.
REQ-017 Read accepted on edge with read=1, waitrequest=0; then x++, at x=WIDTH-1 x=0 and y++.
REQ-018 Credit: outstanding reads + FIFO occupancy SHALL never exceed FIFO_DEPTH; read deasserted when equal.
REQ-019 After last pixel (WIDTH-1,HEIGHT-1) accepted: FETCH->DRAIN.
REQ-020 Each readdatavalid pushes readdata into FIFO, in order; overflow impossible by REQ-018.
REQ-021 aso_out_valid = FIFO non-empty; pop on valid&&ready; data first-word-fall-through.
REQ-022 startofpacket with pixel (0,0); endofpacket with pixel (WIDTH-1,HEIGHT-1); both qualified by valid.
REQ-023 DRAIN->IDLE when outstanding=0 and FIFO empty and last pop done; same edge Busy=0, Done=1.
REQ-024 Abort write in FETCH/DRAIN: stop new reads (finish any read held by waitrequest), discard returning data and FIFO contents, go IDLE once outstanding=0, set Aborted, Done stays 0; Abort in IDLE ignored.
REQ-025 Simultaneous push and pop on same edge: occupancy unchanged, both succeed, including full and empty FIFO cases.
REQ-026 readdatavalid while outstanding=0: ignored (protocol error, no state change).

Reset
REQ-027 resetn=0 at edge: FSM IDLE, BASE=0, x=y=0, outstanding=0, FIFO empty, STATUS=0, FRAMES=0.
REQ-028 Reset values: avm_master_read=0, avm_master_address=0, aso_out_valid=0, sop=eop=0, avs_slave_readdata reflects reset registers.
REQ-029 Reset mid-frame abandons outstanding reads; later readdatavalid handled per REQ-026.

Configuration
REQ-030 Macro PIXEL_READER_FRAMECOUNT_EN defined: FRAMES is 32-bit count of completed frames (increments at REQ-023 transition, wraps 2^32-1->0, not on abort).
REQ-031 Macro undefined: FRAMES reads 0, no counter flops.

Verification
REQ-032 WIDTH=4, HEIGHT=2, BASE=0x1000, no stalls, ready=1 -> addresses 0x1000,02,04,06,0x1400..0x1406; 8 pixels out in order; sop on 1st, eop on 8th; Done=1.
REQ-033 FIFO_DEPTH=4, ready=0 -> exactly 4 reads issued, then read=0; ready=1 -> resumes; no data loss.
REQ-034 waitrequest=1 for 3 cycles on 2nd read -> address/read stable; x advances only after acceptance.
REQ-035 Abort after 3 accepted reads, 2 returned -> remaining returns discarded, IDLE, STATUS=0x4, no eop emitted.
REQ-036 Go written while Busy -> ignored; with FRAMECOUNT_EN two completed frames give FRAMES=2, without it FRAMES=0.
REQ-037 resetn=0 mid-FETCH -> next cycle read=0, valid=0, STATUS=0; subsequent Go runs full frame correctly.
